// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the superscalar ID-stage hazard controller.
package hazard_pkg;

  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;

  // Width of a per-register countdown that must hold values 0..load_lat.
  function automatic int cnt_width(input int load_lat);
    return $clog2(load_lat + 1);
  endfunction

  // Low bit of lane `lane` inside a bus of lanes packed field_w bits apart.
  function automatic int lane_lsb(input int lane, input int field_w);
    return lane * field_w;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register load-latency scoreboard: a register is busy while its
// countdown, loaded when a load to it issues, is nonzero.
module hazard_scoreboard #(
  parameter int ISSUE_W  = 2,
  parameter int LOAD_LAT = 1,
  parameter int REG_AW   = hazard_pkg::REG_AW
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2*ISSUE_W*REG_AW-1:0]   i_lk_reg,
  output logic [2*ISSUE_W-1:0]          o_lk_busy,
  input  logic [ISSUE_W*REG_AW-1:0]     i_set_rd,
  input  logic [ISSUE_W-1:0]            i_set_en
);
  import hazard_pkg::*;

  localparam int CW    = cnt_width(LOAD_LAT);
  localparam int NREGS = 1 << REG_AW;

  logic [CW-1:0]    r_cnt [1:NREGS-1];
  logic [NREGS-1:1] w_set;
  logic [NREGS-1:0] w_busy;

  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    w_set  = '0;
    w_busy = '0;
    for (int r = 1; r < NREGS; r++) begin
      for (int l = 0; l < ISSUE_W; l++) begin
        if (i_set_en[l] && (i_set_rd[lane_lsb(l, REG_AW) +: REG_AW] == REG_AW'(r)))
          w_set[r] = 1'b1;
      end
      w_busy[r] = (r_cnt[r] != '0);
    end
  end

  always_comb begin
    o_lk_busy = '0;
    for (int p = 0; p < 2*ISSUE_W; p++)
      o_lk_busy[p] = w_busy[i_lk_reg[lane_lsb(p, REG_AW) +: REG_AW]];
  end

  // A fresh load restarts the countdown even if an older one is still running.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this array is control state, not data storage, so every entry is reset.
      for (int r = 1; r < NREGS; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (w_set[r])
          r_cnt[r] <= CW'(LOAD_LAT);
        else if (r_cnt[r] != '0)
          r_cnt[r] <= r_cnt[r] - CW'(1);
      end
    end
  end

endmodule

// File: rtl/hazard_issue_ctrl.sv
// In-order multi-lane issue control for the ID stage: scoreboard and
// intra-bundle RAW checks, bundle splitting, stall and bubble generation.
module hazard_issue_ctrl #(
  parameter int ISSUE_W  = 2,
  parameter int LOAD_LAT = 1,
  parameter int REG_AW   = hazard_pkg::REG_AW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [ISSUE_W-1:0]         id_valid,
  input  logic [ISSUE_W*REG_AW-1:0]  id_rs,
  input  logic [ISSUE_W*REG_AW-1:0]  id_rt,
  input  logic [ISSUE_W*REG_AW-1:0]  id_rd,
  input  logic [ISSUE_W-1:0]         id_reg_write,
  input  logic [ISSUE_W-1:0]         id_mem_read,
  output logic [ISSUE_W-1:0]         issue,
  output logic [ISSUE_W-1:0]         bubble,
  output logic                       pc_write,
  output logic                       ifid_write,
  output logic                       split_active
);
  import hazard_pkg::*;

  logic [ISSUE_W-1:0]          r_done;
  logic [ISSUE_W-1:0]          w_pending;
  logic [ISSUE_W-1:0]          w_issue;
  logic [ISSUE_W-1:0]          w_sb_hz;
  logic [ISSUE_W-1:0]          w_set_en;
  logic [2*ISSUE_W*REG_AW-1:0] w_lk_reg;
  logic [2*ISSUE_W-1:0]        w_lk_busy;
  logic                        w_all_issued;

  // Lookup ports 0..ISSUE_W-1 carry rs, ISSUE_W..2*ISSUE_W-1 carry rt.
  assign w_lk_reg  = {id_rt, id_rs};
  assign w_pending = id_valid & ~r_done;

  hazard_scoreboard #(
    .ISSUE_W  (ISSUE_W),
    .LOAD_LAT (LOAD_LAT),
    .REG_AW   (REG_AW)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .i_lk_reg  (w_lk_reg),
    .o_lk_busy (w_lk_busy),
    .i_set_rd  (id_rd),
    .i_set_en  (w_set_en)
  );

  always_comb begin
    w_sb_hz = '0;
    for (int i = 0; i < ISSUE_W; i++)
      w_sb_hz[i] = w_lk_busy[i] | w_lk_busy[ISSUE_W + i];
  end

  // A lane issues only if every older pending lane issues too; forwarding
  // covers same-cycle producers only once they have left ID, hence the RAW check.
  always_comb begin
    logic [ISSUE_W-1:0] iss;
    logic               chain_ok;
    logic               raw;
    logic [REG_AW-1:0]  rd_k;
    iss      = '0;
    chain_ok = 1'b1;
    raw      = 1'b0;
    rd_k     = '0;
    for (int j = 0; j < ISSUE_W; j++) begin
      raw = 1'b0;
      for (int k = 0; k < j; k++) begin
        rd_k = id_rd[lane_lsb(k, REG_AW) +: REG_AW];
        if (iss[k] && id_reg_write[k] && (rd_k != '0) &&
            ((rd_k == id_rs[lane_lsb(j, REG_AW) +: REG_AW]) ||
             (rd_k == id_rt[lane_lsb(j, REG_AW) +: REG_AW])))
          raw = 1'b1;
      end
      if (w_pending[j]) begin
        if (chain_ok && !w_sb_hz[j] && !raw)
          iss[j] = 1'b1;
        else
          chain_ok = 1'b0;
      end
    end
    w_issue = flush ? '0 : iss;
  end

  always_comb begin
    w_set_en = '0;
    for (int i = 0; i < ISSUE_W; i++)
      w_set_en[i] = w_issue[i] & id_mem_read[i] & id_reg_write[i] &
                    (id_rd[lane_lsb(i, REG_AW) +: REG_AW] != '0);
  end

  assign w_all_issued = ((w_pending & ~w_issue) == '0);
  assign issue        = w_issue;
  assign bubble       = id_valid & ~w_issue;
  assign pc_write     = flush | w_all_issued;
  assign ifid_write   = flush | w_all_issued;
  assign split_active = |r_done;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset)
      r_done <= '0;
    else if (flush || w_all_issued)
      r_done <= '0;
    else
      r_done <= r_done | w_issue;
  end

endmodule

// File: tb/tb_hazard_issue_ctrl.sv
// Directed bench: a single-lane LOAD_LAT=1 instance and a two-lane LOAD_LAT=3 instance.
module tb_hazard_issue_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  // Instance A: ISSUE_W=1, LOAD_LAT=1
  logic       a_flush;
  logic [0:0] a_valid, a_rw, a_mr;
  logic [4:0] a_rs, a_rt, a_rd;
  logic [0:0] a_issue, a_bubble;
  logic       a_pcw, a_ifw, a_split;

  // Instance B: ISSUE_W=2, LOAD_LAT=3
  logic       b_flush;
  logic [1:0] b_valid, b_rw, b_mr;
  logic [9:0] b_rs, b_rt, b_rd;
  logic [1:0] b_issue, b_bubble;
  logic       b_pcw, b_ifw, b_split;

  hazard_issue_ctrl #(.ISSUE_W(1), .LOAD_LAT(1), .REG_AW(5)) u_dut_a (
    .clk(clk), .reset(reset), .flush(a_flush), .id_valid(a_valid),
    .id_rs(a_rs), .id_rt(a_rt), .id_rd(a_rd), .id_reg_write(a_rw),
    .id_mem_read(a_mr), .issue(a_issue), .bubble(a_bubble),
    .pc_write(a_pcw), .ifid_write(a_ifw), .split_active(a_split)
  );

  hazard_issue_ctrl #(.ISSUE_W(2), .LOAD_LAT(3), .REG_AW(5)) u_dut_b (
    .clk(clk), .reset(reset), .flush(b_flush), .id_valid(b_valid),
    .id_rs(b_rs), .id_rt(b_rt), .id_rd(b_rd), .id_reg_write(b_rw),
    .id_mem_read(b_mr), .issue(b_issue), .bubble(b_bubble),
    .pc_write(b_pcw), .ifid_write(b_ifw), .split_active(b_split)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic a_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic rw, input logic mr);
    a_valid[0] = v; a_rs = rs; a_rt = rt; a_rd = rd; a_rw[0] = rw; a_mr[0] = mr;
  endtask

  task automatic b_lane(input int l, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic rw, input logic mr);
    b_valid[l] = v; b_rs[l*5 +: 5] = rs; b_rt[l*5 +: 5] = rt;
    b_rd[l*5 +: 5] = rd; b_rw[l] = rw; b_mr[l] = mr;
  endtask

  task automatic b_idle;
    b_valid = '0; b_rs = '0; b_rt = '0; b_rd = '0; b_rw = '0; b_mr = '0;
  endtask

  task automatic test_reset;
    a_set(0, 0, 0, 0, 0, 0);
    b_lane(0, 1, 1, 2, 3, 1, 0);
    b_lane(1, 1, 4, 5, 6, 1, 0);
    settle;
    n_checks++; if (a_issue !== 1'b0) $display("FAIL reset_a_issue: got %b want 0", a_issue); else n_pass++;
    n_checks++; if (a_bubble !== 1'b0) $display("FAIL reset_a_bubble: got %b want 0", a_bubble); else n_pass++;
    n_checks++; if (a_pcw !== 1'b1) $display("FAIL reset_a_pc_write: got %b want 1", a_pcw); else n_pass++;
    n_checks++; if (a_ifw !== 1'b1) $display("FAIL reset_a_ifid_write: got %b want 1", a_ifw); else n_pass++;
    n_checks++; if (a_split !== 1'b0) $display("FAIL reset_a_split: got %b want 0", a_split); else n_pass++;
    n_checks++; if (b_issue !== 2'b11) $display("FAIL reset_b_issue: got %b want 11", b_issue); else n_pass++;
    n_checks++; if (b_bubble !== 2'b00) $display("FAIL reset_b_bubble: got %b want 00", b_bubble); else n_pass++;
    n_checks++; if (b_split !== 1'b0) $display("FAIL reset_b_split: got %b want 0", b_split); else n_pass++;
    tick;
    b_idle;
  endtask

  task automatic test_load_use;
    a_set(1, 1, 2, 5, 1, 1);
    settle;
    n_checks++; if (a_issue !== 1'b1) $display("FAIL lu_load_issue: got %b want 1", a_issue); else n_pass++;
    tick;
    a_set(1, 5, 0, 6, 1, 0);
    settle;
    n_checks++; if (a_issue !== 1'b0) $display("FAIL lu_stall_issue: got %b want 0", a_issue); else n_pass++;
    n_checks++; if (a_bubble !== 1'b1) $display("FAIL lu_stall_bubble: got %b want 1", a_bubble); else n_pass++;
    n_checks++; if (a_pcw !== 1'b0) $display("FAIL lu_stall_pc_write: got %b want 0", a_pcw); else n_pass++;
    n_checks++; if (a_ifw !== 1'b0) $display("FAIL lu_stall_ifid_write: got %b want 0", a_ifw); else n_pass++;
    tick;
    settle;
    n_checks++; if (a_issue !== 1'b1) $display("FAIL lu_resume_issue: got %b want 1", a_issue); else n_pass++;
    n_checks++; if (a_bubble !== 1'b0) $display("FAIL lu_resume_bubble: got %b want 0", a_bubble); else n_pass++;
    n_checks++; if (a_pcw !== 1'b1) $display("FAIL lu_resume_pc_write: got %b want 1", a_pcw); else n_pass++;
    tick;
    // load r8 followed by a reader on the rt port
    a_set(1, 1, 2, 8, 1, 1);
    tick;
    a_set(1, 3, 8, 9, 1, 0);
    settle;
    n_checks++; if (a_issue !== 1'b0) $display("FAIL lu_rt_stall_issue: got %b want 0", a_issue); else n_pass++;
    tick;
    settle;
    n_checks++; if (a_issue !== 1'b1) $display("FAIL lu_rt_resume_issue: got %b want 1", a_issue); else n_pass++;
    tick;
    a_set(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_long_latency;
    b_idle;
    b_lane(0, 1, 1, 2, 7, 1, 1);
    settle;
    n_checks++; if (b_issue !== 2'b01) $display("FAIL ll_load_issue: got %b want 01", b_issue); else n_pass++;
    tick;
    b_lane(0, 1, 7, 0, 8, 1, 0);
    for (int c = 0; c < 3; c++) begin
      settle;
      n_checks++; if (b_issue !== 2'b00) $display("FAIL ll_stall%0d_issue: got %b want 00", c, b_issue); else n_pass++;
      n_checks++; if (b_pcw !== 1'b0) $display("FAIL ll_stall%0d_pc_write: got %b want 0", c, b_pcw); else n_pass++;
      tick;
    end
    settle;
    n_checks++; if (b_issue !== 2'b01) $display("FAIL ll_resume_issue: got %b want 01", b_issue); else n_pass++;
    n_checks++; if (b_pcw !== 1'b1) $display("FAIL ll_resume_pc_write: got %b want 1", b_pcw); else n_pass++;
    tick;
    b_lane(0, 1, 1, 2, 7, 1, 1);
    tick;
    b_lane(0, 1, 8, 9, 10, 1, 0);
    settle;
    n_checks++; if (b_issue !== 2'b01) $display("FAIL ll_indep_issue: got %b want 01", b_issue); else n_pass++;
    tick;
    b_idle;
    repeat (3) tick;
  endtask

  task automatic test_reg0;
    b_idle;
    b_lane(0, 1, 1, 2, 0, 1, 1);
    tick;
    b_lane(0, 1, 0, 0, 11, 1, 0);
    settle;
    n_checks++; if (b_issue !== 2'b01) $display("FAIL r0_reader_issue: got %b want 01", b_issue); else n_pass++;
    tick;
    b_lane(0, 1, 1, 2, 0, 1, 0);
    b_lane(1, 1, 0, 0, 12, 1, 0);
    settle;
    n_checks++; if (b_issue !== 2'b11) $display("FAIL r0_intra_issue: got %b want 11", b_issue); else n_pass++;
    n_checks++; if (b_pcw !== 1'b1) $display("FAIL r0_intra_pc_write: got %b want 1", b_pcw); else n_pass++;
    tick;
    b_idle;
  endtask

  task automatic test_intra_split;
    b_lane(0, 1, 1, 2, 3, 1, 0);
    b_lane(1, 1, 3, 4, 10, 1, 0);
    settle;
    n_checks++; if (b_issue !== 2'b01) $display("FAIL split_c1_issue: got %b want 01", b_issue); else n_pass++;
    n_checks++; if (b_bubble !== 2'b10) $display("FAIL split_c1_bubble: got %b want 10", b_bubble); else n_pass++;
    n_checks++; if (b_pcw !== 1'b0) $display("FAIL split_c1_pc_write: got %b want 0", b_pcw); else n_pass++;
    n_checks++; if (b_split !== 1'b0) $display("FAIL split_c1_split: got %b want 0", b_split); else n_pass++;
    tick;
    settle;
    n_checks++; if (b_issue !== 2'b10) $display("FAIL split_c2_issue: got %b want 10", b_issue); else n_pass++;
    n_checks++; if (b_bubble !== 2'b01) $display("FAIL split_c2_bubble: got %b want 01", b_bubble); else n_pass++;
    n_checks++; if (b_pcw !== 1'b1) $display("FAIL split_c2_pc_write: got %b want 1", b_pcw); else n_pass++;
    n_checks++; if (b_ifw !== 1'b1) $display("FAIL split_c2_ifid_write: got %b want 1", b_ifw); else n_pass++;
    n_checks++; if (b_split !== 1'b1) $display("FAIL split_c2_split: got %b want 1", b_split); else n_pass++;
    tick;
    b_lane(1, 1, 4, 3, 10, 1, 0);
    settle;
    n_checks++; if (b_issue !== 2'b01) $display("FAIL split_rt_issue: got %b want 01", b_issue); else n_pass++;
    tick;
    settle;
    n_checks++; if (b_issue !== 2'b10) $display("FAIL split_rt_c2_issue: got %b want 10", b_issue); else n_pass++;
    tick;
    b_lane(0, 1, 1, 2, 3, 0, 0);
    settle;
    n_checks++; if (b_issue !== 2'b11) $display("FAIL split_nowrite_issue: got %b want 11", b_issue); else n_pass++;
    n_checks++; if (b_split !== 1'b0) $display("FAIL split_nowrite_split: got %b want 0", b_split); else n_pass++;
    tick;
    b_idle;
  endtask

  task automatic test_sb_blocks;
    b_lane(0, 1, 1, 2, 12, 1, 1);
    tick;
    b_lane(0, 1, 12, 0, 13, 1, 0);
    b_lane(1, 1, 1, 2, 14, 1, 0);
    settle;
    n_checks++; if (b_issue !== 2'b00) $display("FAIL sb_block_issue: got %b want 00", b_issue); else n_pass++;
    n_checks++; if (b_bubble !== 2'b11) $display("FAIL sb_block_bubble: got %b want 11", b_bubble); else n_pass++;
    n_checks++; if (b_pcw !== 1'b0) $display("FAIL sb_block_pc_write: got %b want 0", b_pcw); else n_pass++;
    n_checks++; if (b_split !== 1'b0) $display("FAIL sb_block_split: got %b want 0", b_split); else n_pass++;
    repeat (3) tick;
    settle;
    n_checks++; if (b_issue !== 2'b11) $display("FAIL sb_release_issue: got %b want 11", b_issue); else n_pass++;
    n_checks++; if (b_pcw !== 1'b1) $display("FAIL sb_release_pc_write: got %b want 1", b_pcw); else n_pass++;
    tick;
    b_idle;
  endtask

  task automatic test_split_load;
    b_lane(0, 1, 1, 2, 14, 1, 1);
    b_lane(1, 1, 14, 0, 15, 1, 0);
    settle;
    n_checks++; if (b_issue !== 2'b01) $display("FAIL sl_c1_issue: got %b want 01", b_issue); else n_pass++;
    tick;
    settle;
    n_checks++; if (b_issue !== 2'b00) $display("FAIL sl_c2_issue: got %b want 00", b_issue); else n_pass++;
    n_checks++; if (b_bubble !== 2'b11) $display("FAIL sl_c2_bubble: got %b want 11", b_bubble); else n_pass++;
    n_checks++; if (b_split !== 1'b1) $display("FAIL sl_c2_split: got %b want 1", b_split); else n_pass++;
    repeat (2) tick;
    settle;
    n_checks++; if (b_issue !== 2'b00) $display("FAIL sl_c4_issue: got %b want 00", b_issue); else n_pass++;
    tick;
    settle;
    n_checks++; if (b_issue !== 2'b10) $display("FAIL sl_c5_issue: got %b want 10", b_issue); else n_pass++;
    n_checks++; if (b_bubble !== 2'b01) $display("FAIL sl_c5_bubble: got %b want 01", b_bubble); else n_pass++;
    n_checks++; if (b_pcw !== 1'b1) $display("FAIL sl_c5_pc_write: got %b want 1", b_pcw); else n_pass++;
    tick;
    b_idle;
  endtask

  task automatic test_flush;
    b_lane(0, 1, 1, 2, 3, 1, 0);
    b_lane(1, 1, 3, 4, 10, 1, 0);
    tick;
    b_flush = 1'b1;
    settle;
    n_checks++; if (b_issue !== 2'b00) $display("FAIL fl_issue: got %b want 00", b_issue); else n_pass++;
    n_checks++; if (b_bubble !== 2'b11) $display("FAIL fl_bubble: got %b want 11", b_bubble); else n_pass++;
    n_checks++; if (b_pcw !== 1'b1) $display("FAIL fl_pc_write: got %b want 1", b_pcw); else n_pass++;
    n_checks++; if (b_ifw !== 1'b1) $display("FAIL fl_ifid_write: got %b want 1", b_ifw); else n_pass++;
    n_checks++; if (b_split !== 1'b1) $display("FAIL fl_split_before: got %b want 1", b_split); else n_pass++;
    tick;
    b_flush = 1'b0;
    settle;
    n_checks++; if (b_split !== 1'b0) $display("FAIL fl_split_after: got %b want 0", b_split); else n_pass++;
    n_checks++; if (b_issue !== 2'b01) $display("FAIL fl_reissue: got %b want 01", b_issue); else n_pass++;
    b_idle;
    tick;
    // a load squashed by flush leaves no counter behind
    b_flush = 1'b1;
    b_lane(0, 1, 1, 2, 16, 1, 1);
    tick;
    b_flush = 1'b0;
    b_lane(0, 1, 16, 0, 17, 1, 0);
    settle;
    n_checks++; if (b_issue !== 2'b01) $display("FAIL fl_noset_issue: got %b want 01", b_issue); else n_pass++;
    tick;
    // counters keep draining while flush is held
    b_lane(0, 1, 1, 2, 18, 1, 1);
    tick;
    b_flush = 1'b1;
    b_lane(0, 1, 18, 0, 19, 1, 0);
    repeat (3) tick;
    b_flush = 1'b0;
    settle;
    n_checks++; if (b_issue !== 2'b01) $display("FAIL fl_drain_issue: got %b want 01", b_issue); else n_pass++;
    tick;
    b_idle;
  endtask

  task automatic test_reset_mid;
    b_lane(0, 1, 1, 2, 9, 1, 1);
    tick;
    b_lane(0, 1, 1, 2, 3, 1, 0);
    b_lane(1, 1, 3, 4, 10, 1, 0);
    tick;
    settle;
    n_checks++; if (b_split !== 1'b1) $display("FAIL rm_split_before: got %b want 1", b_split); else n_pass++;
    reset   = 1'b1;
    b_flush = 1'b1;
    tick;
    reset   = 1'b0;
    b_flush = 1'b0;
    b_lane(0, 1, 9, 0, 20, 1, 0);
    b_lane(1, 1, 1, 2, 21, 1, 0);
    settle;
    n_checks++; if (b_issue !== 2'b11) $display("FAIL rm_r9_issue: got %b want 11", b_issue); else n_pass++;
    n_checks++; if (b_split !== 1'b0) $display("FAIL rm_split_after: got %b want 0", b_split); else n_pass++;
    n_checks++; if (b_pcw !== 1'b1) $display("FAIL rm_pc_write: got %b want 1", b_pcw); else n_pass++;
    tick;
    b_idle;
  endtask

  initial begin
    reset   = 1'b1;
    a_flush = 1'b0;
    b_flush = 1'b0;
    a_set(0, 0, 0, 0, 0, 0);
    b_idle;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset;
    test_load_use;
    test_long_latency;
    test_reg0;
    test_intra_split;
    test_sb_blocks;
    test_split_load;
    test_flush;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
